// File: rtl/spi_master_if.sv
// spi_master_if -- host-side request/response signals and SPI pins of one SPI master.
//
// Handshake: the host holds spi_ready_send high, with spi_data_in valid, for as
// long as it wants a transfer. The master accepts on a rising clk edge when it
// is idle, which is when spi_busy is low and the previous DONE cycle has
// retired. Once spi_busy rises the request is consumed. A request that is still
// high when the master returns to idle starts another transfer. spi_data_out is
// valid from the cycle spi_busy falls until the next transfer completes.
//
// Signals:
//   spi_data_in    host -> master  byte to send
//   spi_ready_send host -> master  transfer request (level)
//   spi_busy       master -> host  transfer in progress
//   spi_data_out   master -> host  last received byte
//   sclk, mosi, ss_n  master -> slave  SPI mode 0 pins
//   miso           slave -> master  serial data in
interface spi_master_if;
    logic [7:0] spi_data_in;
    logic       spi_ready_send;
    logic       spi_busy;
    logic [7:0] spi_data_out;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    modport master (
        input  spi_data_in, spi_ready_send, miso,
        output spi_busy, spi_data_out, sclk, mosi, ss_n
    );

    modport slave (
        output spi_data_in, spi_ready_send, miso,
        input  spi_busy, spi_data_out, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master.sv
// spi_master -- single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        spi_master_if.master: host handshake and SPI pins
//   state_dbg  current FSM state (IDLE=0, XFER=1, DONE=2) for observation
//
// Parameter CLK_DIV (2..255) is the sclk half-period in clk cycles. A transfer
// keeps spi_busy high for 16*CLK_DIV cycles and is followed by one DONE cycle
// in which the received byte is published.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] tx_sh;    // tx_sh[7] is the bit currently on mosi
    logic [7:0] rx_sh;
    logic [7:0] div_cnt;  // clk cycles elapsed in the current sclk half-period
    logic [2:0] bit_cnt;  // index of the bit in flight; advances between bits

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tx_sh            <= 8'h00;
            rx_sh            <= 8'h00;
            div_cnt          <= 8'h00;
            bit_cnt          <= 3'd0;
            bus.spi_busy     <= 1'b0;
            bus.spi_data_out <= 8'h00;
            bus.sclk         <= 1'b0;
            bus.mosi         <= 1'b0;
            bus.ss_n         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.spi_ready_send) begin
                        tx_sh        <= bus.spi_data_in;
                        rx_sh        <= 8'h00;
                        div_cnt      <= 8'h00;
                        bit_cnt      <= 3'd0;
                        bus.spi_busy <= 1'b1;
                        bus.ss_n     <= 1'b0;
                        bus.sclk     <= 1'b0;
                        bus.mosi     <= bus.spi_data_in[7];
                        state        <= XFER;
                    end
                end

                XFER: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 8'h00;
                        bus.sclk <= ~bus.sclk;
                        if (!bus.sclk) begin
                            // Rising edge: mode 0 samples here.
                            rx_sh <= {rx_sh[6:0], bus.miso};
                        end else if (bit_cnt == 3'd7) begin
                            // Falling edge after the last bit: sclk is back at 0,
                            // so deselect the slave and publish in the same edge.
                            bus.spi_busy     <= 1'b0;
                            bus.ss_n         <= 1'b1;
                            bus.mosi         <= 1'b0;
                            bus.spi_data_out <= rx_sh;
                            state            <= DONE;
                        end else begin
                            // Falling edge: present the next lower bit.
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            bus.mosi <= tx_sh[6];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- self-checking bench for spi_master (CLK_DIV=4 and CLK_DIV=2).
module tb_spi_master;
    logic clk;
    logic rst;
    logic [1:0] state_a;
    logic [1:0] state_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_master_if bus_a();
    spi_master_if bus_b();

    spi_master #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
    );
    spi_master #(.CLK_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
    );

    // ---------------- slave model for dut_a ----------------
    // Presents slave_byte MSB first: bit 7 while selected, next bit after each
    // sclk fall. loop_en replaces it by a mosi->miso wire.
    logic       loop_en = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         slave_idx = 0;
    logic       slave_ps = 1'b0;
    logic       slave_bit;

    assign slave_bit    = (slave_idx < 8) ? slave_byte[3'(7 - slave_idx)] : 1'b0;
    assign bus_a.miso   = loop_en ? bus_a.mosi : slave_bit;
    assign bus_b.miso   = bus_b.mosi;

    always @(negedge clk) begin
        if (bus_a.ss_n) slave_idx <= 0;
        else if (slave_ps && !bus_a.sclk) slave_idx <= slave_idx + 1;
        slave_ps <= bus_a.sclk;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // One transfer on dut_a, observed at every falling clk edge.
    task automatic do_xfer(input logic [7:0] tx, input logic lp, input logic [7:0] sb,
                           input logic pulse,
                           output int busy_n, output int rises, output int falls,
                           output logic [7:0] mosi_byte, output int first_rise,
                           output logic ss_ok, output logic dout_ok,
                           output logic [7:0] dout_end);
        logic [7:0] d0;
        logic ps;
        int guard;
        loop_en    = lp;
        slave_byte = sb;
        @(negedge clk);
        bus_a.spi_data_in    = tx;
        bus_a.spi_ready_send = 1'b1;
        @(negedge clk);
        bus_a.spi_ready_send = 1'b0;
        busy_n = 0; rises = 0; falls = 0; mosi_byte = 8'h00; first_rise = -1;
        ss_ok = 1'b1; dout_ok = 1'b1;
        d0 = bus_a.spi_data_out;
        ps = 1'b0;
        guard = 0;
        while (bus_a.spi_busy === 1'b1 && guard < 1000) begin
            busy_n++;
            guard++;
            if (bus_a.sclk && !ps) begin
                rises++;
                mosi_byte = {mosi_byte[6:0], bus_a.mosi};
                if (first_rise < 0) first_rise = busy_n;
            end
            if (!bus_a.sclk && ps) falls++;
            if (bus_a.sclk && bus_a.ss_n) ss_ok = 1'b0;
            if (bus_a.spi_data_out !== d0) dout_ok = 1'b0;
            ps = bus_a.sclk;
            bus_a.spi_data_in = 8'($urandom_range(0, 255));
            if (pulse && busy_n == 20) begin
                bus_a.spi_data_in    = 8'h11;
                bus_a.spi_ready_send = 1'b1;
            end else begin
                bus_a.spi_ready_send = 1'b0;
            end
            @(negedge clk);
        end
        if (!bus_a.sclk && ps) falls++;
        dout_end = bus_a.spi_data_out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus_a.spi_ready_send = 1'b1;  // reset must win over a request
        bus_a.spi_data_in    = 8'hFF;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_a.spi_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus_a.spi_busy); end
        n_checks++; if (bus_a.ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b, required 1", bus_a.ss_n); end
        n_checks++; if (bus_a.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b, required 0", bus_a.sclk); end
        n_checks++; if (bus_a.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b, required 0", bus_a.mosi); end
        n_checks++; if (bus_a.spi_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h, required 00", bus_a.spi_data_out); end
        bus_a.spi_ready_send = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus_a.spi_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", bus_a.spi_busy); end
    endtask

    task automatic test_loopback();
        int bn, r, f, fr; logic [7:0] mb, de; logic sok, dok;
        do_xfer(8'hA5, 1'b1, 8'h00, 1'b0, bn, r, f, mb, fr, sok, dok, de);
        n_checks++; if (bn !== 64) begin n_fail++; $display("FAIL loop_busy_len: got %0d, required 64", bn); end
        n_checks++; if (r !== 8) begin n_fail++; $display("FAIL loop_rises: got %0d, required 8", r); end
        n_checks++; if (f !== 8) begin n_fail++; $display("FAIL loop_falls: got %0d, required 8", f); end
        n_checks++; if (fr !== 5) begin n_fail++; $display("FAIL loop_first_rise: got busy cycle %0d, required 5", fr); end
        n_checks++; if (mb !== 8'hA5) begin n_fail++; $display("FAIL loop_mosi: got %h, required a5", mb); end
        n_checks++; if (de !== 8'hA5) begin n_fail++; $display("FAIL loop_dout: got %h, required a5", de); end
        n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL loop_sclk_while_deselected: got %b, required 1", sok); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL loop_dout_stable: got %b, required 1", dok); end
        n_checks++; if (bus_a.ss_n !== 1'b1) begin n_fail++; $display("FAIL loop_ss_n_after: got %b, required 1", bus_a.ss_n); end
        n_checks++; if (bus_a.mosi !== 1'b0) begin n_fail++; $display("FAIL loop_mosi_after: got %b, required 0", bus_a.mosi); end
        n_checks++; if (bus_a.sclk !== 1'b0) begin n_fail++; $display("FAIL loop_sclk_after: got %b, required 0", bus_a.sclk); end
        @(negedge clk);
        n_checks++; if (bus_a.spi_data_out !== 8'hA5) begin n_fail++; $display("FAIL loop_dout_hold: got %h, required a5", bus_a.spi_data_out); end
    endtask

    task automatic test_slave();
        int bn, r, f, fr; logic [7:0] mb, de; logic sok, dok;
        do_xfer(8'hFF, 1'b0, 8'h3C, 1'b0, bn, r, f, mb, fr, sok, dok, de);
        n_checks++; if (mb !== 8'hFF) begin n_fail++; $display("FAIL slave_mosi: got %h, required ff", mb); end
        n_checks++; if (de !== 8'h3C) begin n_fail++; $display("FAIL slave_dout: got %h, required 3c", de); end
        n_checks++; if (bn !== 64) begin n_fail++; $display("FAIL slave_busy_len: got %0d, required 64", bn); end
    endtask

    task automatic test_ignore_request();
        int bn, r, f, fr; logic [7:0] mb, de; logic sok, dok; int extra;
        do_xfer(8'h22, 1'b1, 8'h00, 1'b1, bn, r, f, mb, fr, sok, dok, de);
        n_checks++; if (mb !== 8'h22) begin n_fail++; $display("FAIL ignore_mosi: got %h, required 22", mb); end
        n_checks++; if (de !== 8'h22) begin n_fail++; $display("FAIL ignore_dout: got %h, required 22", de); end
        n_checks++; if (bn !== 64) begin n_fail++; $display("FAIL ignore_busy_len: got %0d, required 64", bn); end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.spi_busy === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_second_window: got %0d busy cycles, required 0", extra); end
    endtask

    task automatic test_reset_mid_xfer();
        int bn, r, f, fr, seen, guard; logic [7:0] mb, de; logic sok, dok, ps;
        loop_en = 1'b1;
        @(negedge clk);
        bus_a.spi_data_in    = 8'hC3;
        bus_a.spi_ready_send = 1'b1;
        @(negedge clk);
        bus_a.spi_ready_send = 1'b0;
        seen = 0; ps = 1'b0; guard = 0;
        while (seen < 3 && guard < 200) begin
            if (bus_a.sclk && !ps) seen++;
            ps = bus_a.sclk;
            guard++;
            if (seen < 3) @(negedge clk);
        end
        n_checks++; if (seen !== 3) begin n_fail++; $display("FAIL abort_reach_edge3: got %0d rises, required 3", seen); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_a.spi_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", bus_a.spi_busy); end
        n_checks++; if (bus_a.ss_n !== 1'b1) begin n_fail++; $display("FAIL abort_ss_n: got %b, required 1", bus_a.ss_n); end
        n_checks++; if (bus_a.sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b, required 0", bus_a.sclk); end
        n_checks++; if (bus_a.spi_data_out !== 8'h00) begin n_fail++; $display("FAIL abort_dout: got %h, required 00", bus_a.spi_data_out); end
        rst = 1'b0;
        do_xfer(8'h5A, 1'b1, 8'h00, 1'b0, bn, r, f, mb, fr, sok, dok, de);
        n_checks++; if (mb !== 8'h5A) begin n_fail++; $display("FAIL after_abort_mosi: got %h, required 5a", mb); end
        n_checks++; if (de !== 8'h5A) begin n_fail++; $display("FAIL after_abort_dout: got %h, required 5a", de); end
        n_checks++; if (r !== 8) begin n_fail++; $display("FAIL after_abort_rises: got %0d, required 8", r); end
        n_checks++; if (bn !== 64) begin n_fail++; $display("FAIL after_abort_busy_len: got %0d, required 64", bn); end
    endtask

    task automatic test_back_to_back();
        int lens[$]; int gaps[$];
        int len, gap, win; logic prev_busy, gap_ss_ok, dok; logic [7:0] d0, dlast;
        loop_en = 1'b1;
        @(negedge clk);
        bus_a.spi_data_in    = 8'h81;
        bus_a.spi_ready_send = 1'b1;
        len = 0; gap = 0; win = 0; prev_busy = 1'b0; gap_ss_ok = 1'b1; dok = 1'b1;
        d0 = 8'h00; dlast = 8'h00;
        for (int c = 0; c < 400 && win < 3; c++) begin
            @(negedge clk);
            if (bus_a.spi_busy === 1'b1) begin
                if (!prev_busy) begin
                    if (win > 0) gaps.push_back(gap);
                    d0 = bus_a.spi_data_out;
                    len = 0;
                end
                len++;
                if (bus_a.spi_data_out !== d0) dok = 1'b0;
            end else begin
                if (prev_busy) begin
                    lens.push_back(len);
                    win++;
                    gap = 0;
                    dlast = bus_a.spi_data_out;
                end
                gap++;
                if (bus_a.ss_n !== 1'b1) gap_ss_ok = 1'b0;
            end
            prev_busy = bus_a.spi_busy;
        end
        bus_a.spi_ready_send = 1'b0;
        n_checks++; if (lens.size() !== 3) begin n_fail++; $display("FAIL b2b_windows: got %0d, required 3", lens.size()); end
        foreach (lens[i]) begin
            n_checks++; if (lens[i] !== 64) begin n_fail++; $display("FAIL b2b_len[%0d]: got %0d, required 64", i, lens[i]); end
        end
        foreach (gaps[i]) begin
            // DONE cycle plus exactly one IDLE cycle
            n_checks++; if (gaps[i] !== 2) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d, required 2", i, gaps[i]); end
        end
        n_checks++; if (gap_ss_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ss_n: got %b, required 1", gap_ss_ok); end
        n_checks++; if (dok !== 1'b1) begin n_fail++; $display("FAIL b2b_dout_stable: got %b, required 1", dok); end
        n_checks++; if (dlast !== 8'h81) begin n_fail++; $display("FAIL b2b_dout: got %h, required 81", dlast); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int bn, r, f, fr; logic [7:0] mb, de, tx, sb, exp; logic sok, dok, lp;
        for (int i = 0; i < 6; i++) begin
            tx = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            lp = 1'($urandom_range(0, 1));
            // What the slave shifts in is what the master ends up with.
            exp_q.push_back(lp ? tx : sb);
            do_xfer(tx, lp, sb, 1'b0, bn, r, f, mb, fr, sok, dok, de);
            exp = exp_q.pop_front();
            n_checks++; if (mb !== tx) begin n_fail++; $display("FAIL rand_mosi[%0d]: got %h, required %h", i, mb, tx); end
            n_checks++; if (de !== exp) begin n_fail++; $display("FAIL rand_dout[%0d]: got %h, required %h", i, de, exp); end
            n_checks++; if (bn !== 64) begin n_fail++; $display("FAIL rand_busy_len[%0d]: got %0d, required 64", i, bn); end
        end
    endtask

    task automatic test_clk_div2();
        int bn, r, guard; logic ps;
        @(negedge clk);
        bus_b.spi_data_in    = 8'h0F;
        bus_b.spi_ready_send = 1'b1;
        @(negedge clk);
        bus_b.spi_ready_send = 1'b0;
        bn = 0; r = 0; ps = 1'b0; guard = 0;
        while (bus_b.spi_busy === 1'b1 && guard < 1000) begin
            bn++;
            guard++;
            if (bus_b.sclk && !ps) r++;
            ps = bus_b.sclk;
            @(negedge clk);
        end
        n_checks++; if (bn !== 32) begin n_fail++; $display("FAIL div2_busy_len: got %0d, required 32", bn); end
        n_checks++; if (r !== 8) begin n_fail++; $display("FAIL div2_rises: got %0d, required 8", r); end
        n_checks++; if (bus_b.spi_data_out !== 8'h0F) begin n_fail++; $display("FAIL div2_dout: got %h, required 0f", bus_b.spi_data_out); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1;
        bus_a.spi_data_in = 8'h00; bus_a.spi_ready_send = 1'b0;
        bus_b.spi_data_in = 8'h00; bus_b.spi_ready_send = 1'b0;
        test_reset();
        test_loopback();
        test_slave();
        test_ignore_request();
        test_reset_mid_xfer();
        test_back_to_back();
        test_random();
        test_clk_div2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, sclk half-period in clk cycles; legal range 2..255.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: spi_data_in  input  8  byte to transmit, sampled at transfer accept.
REQ-005 Port: spi_ready_send  input  1  transfer request, level-sensitive, sampled only in IDLE.
REQ-006 Port: spi_busy  output  1  high while a transfer is in progress.
REQ-007 Port: spi_data_out  output  8  last received byte.
REQ-008 Port: sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 Port: mosi  output  1  serial data out, MSB first.
REQ-010 Port: miso  input  1  serial data in, MSB first.
REQ-011 Port: ss_n  output  1  slave select, active-low.

Function
REQ-012 FSM states: IDLE, XFER, DONE; all outputs registered.
REQ-013 IDLE: spi_busy=0, ss_n=1, sclk=0; spi_data_out holds its value.
REQ-014 Accept: at cycle T in IDLE with spi_ready_send=1 -> latch spi_data_in into tx shift register; move to XFER.
REQ-015 At T+1: spi_busy=1, ss_n=0, sclk=0, mosi=tx bit 7, half-period counter cleared.
REQ-016 XFER: sclk toggles every CLK_DIV clk cycles; first rising edge at T+1+CLK_DIV; exactly 8 rising and 8 falling edges.
REQ-017 On each sclk rising edge: sample miso into rx shift register LSB, shifting left.
REQ-018 On each sclk falling edge except the 8th: mosi advances to the next lower tx bit.
REQ-019 Bit counter 0..7 counts rising edges; the 8th falling edge (sclk back to 0) ends XFER -> DONE.
REQ-020 DONE, one cycle, at T+1+16*CLK_DIV: spi_busy=0, ss_n=1, spi_data_out=rx register, mosi=0; next state IDLE.
REQ-021 spi_busy is high for exactly 16*CLK_DIV cycles per transfer (64 at default).
REQ-022 spi_data_out updates only in the same cycle spi_busy falls; it is stable whenever spi_busy=0.
REQ-023 spi_ready_send is ignored in XFER and DONE; no queuing.
REQ-024 spi_ready_send still high in IDLE after DONE -> new transfer accepted (back-to-back); min gap of 1 IDLE cycle with ss_n=1.
REQ-025 spi_data_in changes after accept do not affect the transmitted byte.
REQ-026 ss_n falls no later than sclk leaves 0 and rises no earlier than sclk returns to 0; sclk never toggles with ss_n=1.

Reset
REQ-027 rst=1 at any clock edge, including mid-XFER: state=IDLE, spi_busy=0, ss_n=1, sclk=0, mosi=0, spi_data_out=0x00, shift registers and counters cleared.
REQ-028 Aborted transfer produces no spi_data_out update; the next transfer after reset starts from bit 7.
REQ-029 rst has priority over spi_ready_send in the same cycle.

Verification
REQ-030 Loopback miso=mosi, CLK_DIV=4, send 0xA5 -> spi_busy high 64 cycles, 8 sclk pulses, spi_data_out=0xA5 when spi_busy falls, ss_n=1 after.
REQ-031 miso driven by slave model with 0x3C while sending 0xFF -> mosi high all 8 bits, spi_data_out=0x3C.
REQ-032 spi_ready_send pulsed with 0x11 during an ongoing 0x22 transfer -> ignored; only 0x22 on mosi, one busy window.
REQ-033 rst asserted after 3 rising sclk edges of a transfer -> next cycle spi_busy=0, ss_n=1, sclk=0, spi_data_out=0x00; new 0x5A transfer then completes correctly.
REQ-034 spi_ready_send held high with data 0x81 -> consecutive transfers separated by exactly one IDLE cycle with ss_n=1; spi_data_out constant while spi_busy=1.
REQ-035 CLK_DIV=2 loopback 0x0F -> spi_busy high 32 cycles, spi_data_out=0x0F.
